// File: rtl/gray_dsr_cmd_sched_if.sv
// Request and FSM-side signals of the gray-coded command scheduler.
// The master modport is the environment (requesters plus FSM); the slave modport is the scheduler.
interface gray_dsr_cmd_sched_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [4*N_REQ-1:0] req_cmd;
  logic [N_REQ-1:0]   req_ready;
  logic [3:0]         fsm_cmd;
  logic [7:0]         fsm_out;

  modport master (
    output req_valid, req_cmd, fsm_out,
    input  req_ready, fsm_cmd
  );

  modport slave (
    input  req_valid, req_cmd, fsm_out,
    output req_ready, fsm_cmd
  );
endinterface

// File: rtl/gray_dsr_cmd_sched.sv
// Round-robin scheduler sharing one one-hot command FSM among N_REQ requesters.
// A grant holds its command until the FSM leaves and returns home (8'h01), or MAX_CYC expires.
//
//   state  | meaning
//   -------+----------------------------------------------------------------
//   S_IDLE | fsm_cmd = IDLE_CMD; arbitrate when FSM is home and a request is valid
//   S_RUN  | fsm_cmd = granted command; wait for leave-and-return or timeout
module gray_dsr_cmd_sched #(
  parameter int         N_REQ    = 4,
  parameter logic [3:0] IDLE_CMD = 4'h0,
  parameter int         MAX_CYC  = 64,
  localparam int        GW       = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int        CW       = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gray_dsr_cmd_sched_if.slave  bus,
  output logic                 busy,
  output logic [GW-1:0]        grant_id,
  output logic [N_REQ-1:0]     done,
  output logic                 timeout,
  output logic                 onehot_err
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [3:0]       fsm_cmd_q, fsm_cmd_d;
  logic [GW-1:0]    grant_id_q, grant_id_d;
  logic [GW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             left_q, left_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             onehot_err_q, onehot_err_d;

  logic             home;
  logic             fsm_bad;
  logic             win_found;
  logic [GW-1:0]    win_idx;
  logic [3:0]       win_cmd;
  logic             accept;
  logic             complete;
  logic             expire;
  logic [GW-1:0]    next_ptr;

  assign home    = (bus.fsm_out == 8'h01);
  assign fsm_bad = (bus.fsm_out == 8'h00) ||
                   ((bus.fsm_out & (bus.fsm_out - 8'd1)) != 8'h00);

  // First valid requester scanning upward from rr_ptr, wrapping at N_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_found && bus.req_valid[(int'(rr_ptr_q) + i) % N_REQ]) begin
        win_found = 1'b1;
        win_idx   = GW'((int'(rr_ptr_q) + i) % N_REQ);
      end
    end
  end

  assign win_cmd  = bus.req_cmd[int'(win_idx)*4 +: 4];
  assign accept   = (state_q == S_IDLE) && home && win_found;
  assign complete = (state_q == S_RUN) && left_q && home;
  assign expire   = (cnt_q == CW'(MAX_CYC - 1));
  assign next_ptr = (grant_id_q == GW'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;

  assign bus.req_ready = accept ? (N_REQ'(1) << win_idx) : '0;

  always_comb begin
    state_d      = state_q;
    fsm_cmd_d    = fsm_cmd_q;
    grant_id_d   = grant_id_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    left_d       = left_q;
    done_d       = '0;
    timeout_d    = 1'b0;
    onehot_err_d = onehot_err_q | fsm_bad;
    case (state_q)
      S_IDLE: begin
        fsm_cmd_d = IDLE_CMD;
        if (accept) begin
          state_d    = S_RUN;
          fsm_cmd_d  = win_cmd;
          grant_id_d = win_idx;
          cnt_d      = '0;
          left_d     = 1'b0;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (!home) left_d = 1'b1;
        // Completion takes priority over a timeout landing on the same cycle.
        if (complete || expire) begin
          state_d   = S_IDLE;
          fsm_cmd_d = IDLE_CMD;
          rr_ptr_d  = next_ptr;
          if (complete) done_d    = N_REQ'(1) << grant_id_q;
          else          timeout_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      fsm_cmd_q    <= IDLE_CMD;
      grant_id_q   <= '0;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      left_q       <= 1'b0;
      done_q       <= '0;
      timeout_q    <= 1'b0;
      onehot_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fsm_cmd_q    <= fsm_cmd_d;
      grant_id_q   <= grant_id_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      left_q       <= left_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      onehot_err_q <= onehot_err_d;
    end
  end

  assign bus.fsm_cmd = fsm_cmd_q;
  assign busy        = (state_q == S_RUN);
  assign grant_id    = grant_id_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign onehot_err  = onehot_err_q;

endmodule

// File: tb/tb_gray_dsr_cmd_sched.sv
// Directed bench for gray_dsr_cmd_sched (N_REQ=4, MAX_CYC=8) with hand-computed expectations.
module tb_gray_dsr_cmd_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       busy;
  logic [1:0] grant_id;
  logic [3:0] done;
  logic       timeout;
  logic       onehot_err;

  int vectors     = 0;
  int miscompares = 0;

  int         exp_g [5] = '{0, 1, 2, 3, 0};
  logic [3:0] exp_c [5] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1};

  gray_dsr_cmd_sched_if #(.N_REQ(4)) bus ();

  gray_dsr_cmd_sched #(
    .N_REQ   (4),
    .IDLE_CMD(4'h0),
    .MAX_CYC (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .grant_id  (grant_id),
    .done      (done),
    .timeout   (timeout),
    .onehot_err(onehot_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = 4'b0000;
    bus.req_cmd   = 16'h0000;
    bus.fsm_out   = 8'h01;
    #12;
    chk("rst_fsm_cmd", {28'd0, bus.fsm_cmd}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    chk("rst_grant_id", {30'd0, grant_id}, 32'h0);
    chk("rst_done", {28'd0, done}, 32'h0);
    chk("rst_timeout", {31'd0, timeout}, 32'h0);
    chk("rst_onehot_err", {31'd0, onehot_err}, 32'h0);
    chk("rst_ready", {28'd0, bus.req_ready}, 32'h0);
    rst_n = 1'b1;
    tick();

    // single request on index 2
    bus.req_valid = 4'b0100;
    bus.req_cmd   = 16'h0A00;
    #1 chk("single_ready", {28'd0, bus.req_ready}, 32'h4);
    tick();
    bus.req_valid = 4'b0000;
    chk("single_cmd", {28'd0, bus.fsm_cmd}, 32'hA);
    chk("single_busy", {31'd0, busy}, 32'h1);
    chk("single_gid", {30'd0, grant_id}, 32'h2);
    bus.fsm_out = 8'h02;
    tick();
    chk("single_done_early", {28'd0, done}, 32'h0);
    bus.fsm_out = 8'h01;
    tick();
    chk("single_done", {28'd0, done}, 32'h4);
    chk("single_rel_busy", {31'd0, busy}, 32'h0);
    chk("single_rel_cmd", {28'd0, bus.fsm_cmd}, 32'h0);
    tick();
    chk("single_done_clr", {28'd0, done}, 32'h0);

    // grant index 3 (rr_ptr=3), then asynchronous reset mid-RUN
    bus.req_valid = 4'b1000;
    bus.req_cmd   = 16'hC000;
    #1 chk("midrun_ready", {28'd0, bus.req_ready}, 32'h8);
    tick();
    bus.req_valid = 4'b0000;
    chk("midrun_busy", {31'd0, busy}, 32'h1);
    chk("midrun_cmd", {28'd0, bus.fsm_cmd}, 32'hC);
    chk("midrun_gid", {30'd0, grant_id}, 32'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'h0);
    chk("arst_cmd", {28'd0, bus.fsm_cmd}, 32'h0);
    chk("arst_gid", {30'd0, grant_id}, 32'h0);
    chk("arst_done", {28'd0, done}, 32'h0);
    #1 rst_n = 1'b1;
    tick();

    // round robin with all four valid; rr_ptr restarts at 0
    bus.req_valid = 4'b1111;
    bus.req_cmd   = 16'h4321;
    for (int n = 0; n < 5; n++) begin
      #1 chk($sformatf("rr%0d_ready", n), {28'd0, bus.req_ready}, 32'd1 << exp_g[n]);
      tick();
      chk($sformatf("rr%0d_cmd", n), {28'd0, bus.fsm_cmd}, {28'd0, exp_c[n]});
      chk($sformatf("rr%0d_gid", n), {30'd0, grant_id}, exp_g[n]);
      #1 chk($sformatf("rr%0d_run_ready", n), {28'd0, bus.req_ready}, 32'h0);
      bus.fsm_out = 8'h02;
      tick();
      bus.fsm_out = 8'h01;
      tick();
      chk($sformatf("rr%0d_done", n), {28'd0, done}, 32'd1 << exp_g[n]);
      chk($sformatf("rr%0d_busy", n), {31'd0, busy}, 32'h0);
    end

    // timeout: index 1 (rr_ptr=1), FSM stuck away from home
    bus.req_valid = 4'b0010;
    bus.req_cmd   = 16'h0070;
    #1 chk("to_ready", {28'd0, bus.req_ready}, 32'h2);
    tick();
    bus.req_valid = 4'b0000;
    bus.fsm_out   = 8'h02;
    chk("to_cmd", {28'd0, bus.fsm_cmd}, 32'h7);
    repeat (7) tick();
    chk("to_busy_last", {31'd0, busy}, 32'h1);
    chk("to_early", {31'd0, timeout}, 32'h0);
    tick();
    chk("to_pulse", {31'd0, timeout}, 32'h1);
    chk("to_no_done", {28'd0, done}, 32'h0);
    chk("to_busy", {31'd0, busy}, 32'h0);
    chk("to_cmd_idle", {28'd0, bus.fsm_cmd}, 32'h0);
    tick();
    chk("to_pulse_clr", {31'd0, timeout}, 32'h0);

    // home gate; rr_ptr=2 so winner among {0,1} must be 0
    bus.fsm_out   = 8'h10;
    bus.req_valid = 4'b0011;
    bus.req_cmd   = 16'h0098;
    #1 chk("gate_ready0", {28'd0, bus.req_ready}, 32'h0);
    tick();
    chk("gate_ready1", {28'd0, bus.req_ready}, 32'h0);
    chk("gate_busy", {31'd0, busy}, 32'h0);
    bus.fsm_out = 8'h01;
    #1 chk("gate_ready_home", {28'd0, bus.req_ready}, 32'h1);
    tick();
    bus.req_valid = 4'b0000;
    chk("gate_cmd", {28'd0, bus.fsm_cmd}, 32'h8);
    chk("gate_gid", {30'd0, grant_id}, 32'h0);
    bus.fsm_out = 8'h02;
    tick();
    bus.fsm_out = 8'h01;
    tick();
    chk("gate_done", {28'd0, done}, 32'h1);

    // sticky one-hot error
    chk("err_clear", {31'd0, onehot_err}, 32'h0);
    bus.fsm_out = 8'h03;
    tick();
    bus.fsm_out = 8'h01;
    chk("err_set", {31'd0, onehot_err}, 32'h1);
    chk("err_busy", {31'd0, busy}, 32'h0);
    repeat (3) tick();
    chk("err_sticky", {31'd0, onehot_err}, 32'h1);
    rst_n = 1'b0;
    #1 chk("err_rst", {31'd0, onehot_err}, 32'h0);
    #1 rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
